// File: rtl/stream_pkg.sv
// ============================================================================
// stream_pkg : shared sizing and FSM state type for the byte-stream link
// Revision   : 1.0
// ============================================================================
`default_nettype none

package stream_pkg;

  localparam int DEPTH  = 16;
  localparam int DATA_W = 8;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/rise_det.sv
// ============================================================================
// rise_det : registered rising-edge detector, one-cycle pulse per 0->1 edge
// Revision : 1.0
// ============================================================================
`default_nettype none

module rise_det (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic pulse
);

  logic in_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      in_q  <= 1'b0;
      pulse <= 1'b0;
    end else begin
      in_q  <= in;
      pulse <= in & ~in_q;
    end
  end

endmodule

`default_nettype wire

// File: rtl/stream_sink.sv
// ============================================================================
// stream_sink : stream slave with 16-entry FIFO, pop-edge readout and
//               frame hold-off until a completed frame is fully drained
// Revision    : 1.0
// ============================================================================
`default_nettype none

module stream_sink #(
  parameter  int DEPTH  = stream_pkg::DEPTH,
  parameter  int DATA_W = stream_pkg::DATA_W,
  localparam int CW     = $clog2(DEPTH + 1),
  localparam int PW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tdata,
  input  logic              tvalid,
  output logic              tready,
  input  logic              tlast,
  input  logic              pop,
  output logic [DATA_W-1:0] Dout,
  output logic              dout_valid,
  output logic              dout_last,
  output logic [CW-1:0]     buff_count,
  output logic              empty,
  output logic              full,
  output logic              frame_done,
  output logic [CW-1:0]     frame_len
);

  import stream_pkg::*;

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);
  localparam logic [PW-1:0] ONE_PTR  = PW'(1);

  logic [DATA_W:0] mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   beat_cnt;
  state_t          state;
  state_t          state_nx;
  logic            pop_edge;
  logic            accept;
  logic            service;

  rise_det u_pop_det (
    .clk   (clk),
    .rst   (rst),
    .in    (pop),
    .pulse (pop_edge)
  );

  assign tready     = !rst && (state != HOLD) && (count < FULL_CNT);
  assign accept     = tvalid && tready;
  assign service    = pop_edge && (count != '0);
  assign buff_count = count;
  assign empty      = (count == '0);
  assign full       = (count == FULL_CNT);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = tlast ? HOLD : RECV;
      RECV:    if (accept && tlast) state_nx = HOLD;
      // Only a pop of the very last word releases the hold.
      HOLD:    if (service && count == ONE_CNT) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr] <= {tlast, tdata};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      beat_cnt   <= '0;
      frame_len  <= '0;
      Dout       <= '0;
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      dout_valid <= service;
      frame_done <= service && (state == HOLD) && (count == ONE_CNT);

      case ({accept, service})
        2'b10:   count <= count + ONE_CNT;
        2'b01:   count <= count - ONE_CNT;
        default: count <= count;
      endcase

      if (accept) begin
        wr_ptr <= wr_ptr + ONE_PTR;
        if (tlast) begin
          frame_len <= beat_cnt + ONE_CNT;
          beat_cnt  <= '0;
        end else begin
          beat_cnt  <= beat_cnt + ONE_CNT;
        end
      end

      if (service) begin
        Dout      <= mem[rd_ptr][DATA_W-1:0];
        dout_last <= mem[rd_ptr][DATA_W];
        rd_ptr    <= rd_ptr + ONE_PTR;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_stream_sink.sv
// ============================================================================
// tb_stream_sink : scoreboard bench for stream_sink with a queue-based model
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_stream_sink;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tdata = '0;
  logic       tvalid = 1'b0;
  logic       tready;
  logic       tlast = 1'b0;
  logic       pop = 1'b0;
  logic [7:0] Dout;
  logic       dout_valid;
  logic       dout_last;
  logic [4:0] buff_count;
  logic       empty;
  logic       full;
  logic       frame_done;
  logic [4:0] frame_len;

  stream_sink dut (
    .clk        (clk),
    .rst        (rst),
    .tdata      (tdata),
    .tvalid     (tvalid),
    .tready     (tready),
    .tlast      (tlast),
    .pop        (pop),
    .Dout       (Dout),
    .dout_valid (dout_valid),
    .dout_last  (dout_last),
    .buff_count (buff_count),
    .empty      (empty),
    .full       (full),
    .frame_done (frame_done),
    .frame_len  (frame_len)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: stored beats as {last, data}, plus frame bookkeeping.
  logic [8:0] mq[$];
  logic [9:0] sb[$];
  bit         closed   = 0;
  int         beats    = 0;
  int         flen     = 0;
  bit         pop_prev = 0;
  bit         pend     = 0;
  logic [7:0] exp_dout = '0;
  bit         exp_dv   = 0;
  bit         exp_fd   = 0;
  bit         exp_last = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                  name, act, act, exp, exp, $time);
  endtask

  // Monitor: every presented word must match the oldest predicted word.
  always @(negedge clk) begin
    if (dout_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_dout_valid", 1, 0);
      end else begin
        logic [9:0] e;
        e = sb.pop_front();
        chk("sb_dout", int'(Dout), int'(e[7:0]));
        chk("sb_dout_last", int'(dout_last), int'(e[8]));
        chk("sb_frame_done", int'(frame_done), int'(e[9]));
      end
    end
  end

  task automatic cyc(input bit v, input logic [7:0] d, input bit l, input bit p);
    bit rdy;
    bit acc;
    bit srv;
    logic [8:0] it;
    tvalid = v; tdata = d; tlast = l; pop = p;
    #1;
    rdy = !rst && !closed && (mq.size() < 16);
    chk("tready", int'(tready), int'(rdy));
    acc = v && rdy;
    srv = pend && (mq.size() > 0);
    @(posedge clk);
    exp_dv = 0;
    exp_fd = 0;
    if (rst) begin
      mq.delete();
      closed = 0; beats = 0; flen = 0; pop_prev = 0; pend = 0;
      exp_dout = '0; exp_last = 0;
    end else begin
      if (srv) begin
        it = mq.pop_front();
        exp_dout = it[7:0];
        exp_last = it[8];
        exp_dv = 1;
        exp_fd = closed && (mq.size() == 0);
        if (exp_fd) closed = 0;
        sb.push_back({exp_fd, it});
      end
      if (acc) begin
        mq.push_back({l, d});
        beats++;
        if (l) begin
          flen = beats; beats = 0; closed = 1;
        end
      end
      pend = p && !pop_prev;
      pop_prev = p;
    end
    #1;
    chk("buff_count", int'(buff_count), mq.size());
    chk("empty", int'(empty), int'(mq.size() == 0));
    chk("full", int'(full), int'(mq.size() == 16));
    chk("frame_len", int'(frame_len), flen % 32);
    chk("dout_valid", int'(dout_valid), int'(exp_dv));
    chk("frame_done", int'(frame_done), int'(exp_fd));
    chk("dout_hold", int'(Dout), int'(exp_dout));
    chk("dout_last_hold", int'(dout_last), int'(exp_last));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 8'h00, 0, 0);
  endtask

  task automatic send(input logic [7:0] d, input bit l);
    cyc(1, d, l, 0);
  endtask

  task automatic pop_one();
    cyc(0, 8'h00, 0, 1);
    cyc(0, 8'h00, 0, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (mq.size() > 0 || pend); i++) pop_one();
    idle(2);
    chk("drained", mq.size(), 0);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) cyc(0, 8'h00, 0, 0);
    rst = 1'b0;
  endtask

  initial begin
    int dv;
    @(posedge clk);
    #1;
    do_reset(2);
    idle(1);

    // Three-beat frame
    send(8'hA1, 0); send(8'hB2, 0); send(8'hC3, 1);
    idle(1);
    chk("frame3_len", int'(frame_len), 3);
    drain();

    // Fill to 16, hold off beat 17, pop one, then close the frame with it
    for (int i = 0; i < 16; i++) send(8'(i + 8'h10), 0);
    for (int i = 0; i < 3; i++) send(8'h99, 1);
    chk("full_flag", int'(full), 1);
    pop_one();
    idle(1);
    send(8'h99, 1);
    chk("frame17_len", int'(frame_len), 17);
    drain();

    // Accept and pop serviced in the same cycle at count 5
    for (int i = 0; i < 5; i++) send(8'(8'h30 + i), 0);
    cyc(0, 8'h00, 0, 1);
    cyc(1, 8'h35, 0, 0);
    chk("simul_count", int'(buff_count), 5);
    send(8'h36, 1);
    drain();

    // Pop held high for 10 cycles yields one word; pop on empty is ignored
    send(8'h41, 0); send(8'h42, 1);
    dv = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(0, 8'h00, 0, 1);
      if (dout_valid) dv++;
    end
    chk("held_pop_words", dv, 1);
    drain();
    pop_one(); idle(2);

    // Mid-frame reset discards contents
    for (int i = 0; i < 4; i++) send(8'(8'h60 + i), 0);
    do_reset(1);
    chk("rst_count", int'(buff_count), 0);
    send(8'h55, 1);
    idle(1);
    chk("post_rst_len", int'(frame_len), 1);
    drain();

    // Randomized traffic
    begin
      bit hv = 0;
      logic [7:0] hd = '0;
      bit hl = 0;
      for (int i = 0; i < 2000; i++) begin
        bit v; bit p; bit rdy;
        if ($urandom_range(0, 299) == 0) begin
          do_reset(1);
          hv = 0;
        end
        rdy = !closed && (mq.size() < 16);
        if (!hv) begin
          v  = ($urandom_range(0, 2) != 0);
          hd = 8'($urandom);
          hl = ($urandom_range(0, 6) == 0);
        end else begin
          v = 1;
        end
        p = ($urandom_range(0, 1) == 1);
        cyc(v, hd, hl, p);
        hv = v && !rdy;
      end
    end
    drain();
    chk("sb_empty_end", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/stream_sink.md
# stream_sink

Receive side of the byte-stream interface: an AXI-Stream-style slave that accepts 8-bit beats on `tdata/tvalid/tready/tlast`, stores them in a 16-entry FIFO, and releases them one at a time to the bench or I2C stimulus logic on rising edges of `pop`. It pairs with the stream generator as the consumer at the far end of the same link. It also tracks frame boundaries: once a `tlast` beat is taken, it stops accepting until the frame is fully drained.

## Interface
- `DEPTH`, 16: FIFO entries; power of two.
- `DATA_W`, 8: beat width.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `tdata` in DATA_W: stream data.
- `tvalid` in 1: beat valid from upstream.
- `tready` out 1: sink can accept a beat.
- `tlast` in 1: final beat of a frame.
- `pop` in 1: level input; each rising edge requests one word.
- `Dout` out DATA_W: popped word.
- `dout_valid` out 1: one-cycle pulse when `Dout` updates.
- `dout_last` out 1: `tlast` stored with the word now on `Dout`.
- `buff_count` out 5: entries held, 0..16.
- `empty`, `full` out 1: count==0, count==DEPTH.
- `frame_done` out 1: one-cycle pulse when the last word of a frame is popped.
- `frame_len` out 5: beat count of the most recently received frame.

## Operation
- Storage: FIFO order with `wr_ptr`/`rd_ptr` (4 bits, natural wrap) and `count` (5 bits). Each entry holds {tlast, tdata}.
- FSM states:
  - IDLE: no frame in progress, count==0.
    - Accepted beat with `tlast`=0 → RECV.
    - Accepted beat with `tlast`=1 → HOLD (single-beat frame).
  - RECV: frame in progress.
    - Accepted beat with `tlast`=1 → HOLD.
    - Otherwise stays in RECV, including when full.
  - HOLD: frame fully received; no beats are accepted.
    - When a pop empties the FIFO → IDLE, with `frame_done` pulsing for 1 cycle.
- `tready` is combinational: `!rst && state!=HOLD && count<DEPTH`.
- Accept rule: a beat is taken on a rising `clk` when `tvalid && tready`.
- Frame length: the beat counter increments on each accept. On the `tlast` accept, `frame_len` is loaded with (counter+1) and the counter clears.
- Pop edge detection: register `pop` into `pop_q`. `pop_edge` is registered as `pop & ~pop_q`.
- Pop service: on a cycle with `pop_edge`=1 and count>0:
  - `Dout`/`dout_last` are loaded from `rd_ptr`, `dout_valid` is 1, and `rd_ptr` increments.
- Pop on empty: ignored. `dout_valid` stays 0 and `Dout` holds its value.
- Accept and pop in the same cycle: both happen and count is unchanged. Pop of the final word and accept cannot coincide, because the last word is only popped in HOLD.
- `full`, `empty` and `buff_count` are driven from `count` and are valid in the same cycle.

## Timing
- Reset (`rst` high at a clock edge) clears:
  - state=IDLE, pointers, count, and beat counter.
  - `Dout`=0, `dout_valid`=0, `dout_last`=0, `frame_done`=0, `frame_len`=0.
  - `pop_q`=0, `pop_edge`=0.
- After reset: `empty`=1, `full`=0, `buff_count`=0. `tready` is 0 while `rst` is high and 1 in the first cycle after.
- Reset mid-frame discards all contents; a half-received frame is lost.
- Accept latency: a beat accepted at edge N is reflected in `buff_count` after edge N.
- Pop latency: `pop` rising before edge N gives `pop_edge` after N, and `Dout`/`dout_valid` after N+1.
- Pop spacing: a held-high `pop` yields exactly one word; consecutive pops need `pop` low for ≥1 sampled cycle.
- `frame_done` asserts in the same cycle as the `dout_valid` that drains the FIFO in HOLD.
- `tready` recovers the cycle after state returns to IDLE.
- Upstream `tdata`/`tlast` must be stable while `tvalid`=1 and `tready`=0. The sink imposes no other constraint.

## Structure
- Package `stream_pkg`: `DEPTH`, `DATA_W`, `CNT_W`=5, and the FSM state typedef {IDLE, RECV, HOLD}. Shared with the generator.
- Sub-module `rise_det`: registered rising-edge detector (`clk`, `rst`, `in`, `pulse`), used for `pop`.
- FIFO memory, pointers and FSM live in `stream_sink`. Target size is ~180 RTL lines.

## Test plan
- Reset: hold `rst` 2 cycles → `tready`=0 during reset; afterwards `empty`=1, `buff_count`=0, `tready`=1, all pulses 0.
- Frame of 3: beats 0xA1, 0xB2, 0xC3 (last) → `tready`=0 after the third accept, `frame_len`=3. Three pops yield A1, B2, C3 in order, `dout_last`=1 only on C3, `frame_done` pulses with C3, then `tready`=1.
- Full: 16 beats with `tlast`=0 → `full`=1, `tready`=0, a 17th beat is held off. One pop returns beat 0 and `tready` reasserts. Beat 17 with `tlast` is accepted → `frame_len`=17.
- Simultaneous: accept a beat in the same cycle as a serviced pop at count=5 → count stays 5 and data order is preserved.
- Pop hygiene: `pop` held high 10 cycles → exactly one `dout_valid`. Pop while empty → no `dout_valid`, `Dout` unchanged.
- Mid-frame reset: after 4 beats, pulse `rst` → count=0, state IDLE. A new frame of 0x55 (last) gives `frame_len`=1 and pops 0x55.
